// File: rtl/dbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_pkg
//  Purpose  : Shared encodings, byte-count helpers and FSM state type for the
//             read-side lane packer.
//  Revision : 1.0 - initial release
// ============================================================================
package dbus_pkg;

   localparam logic [1:0] SZ_1B = 2'b00;
   localparam logic [1:0] SZ_2B = 2'b01;
   localparam logic [1:0] SZ_4B = 2'b10;
   localparam logic [1:0] SZ_8B = 2'b11;

   localparam logic [1:0] BW_8  = 2'b00;
   localparam logic [1:0] BW_16 = 2'b01;
   localparam logic [1:0] BW_32 = 2'b10;
   localparam logic [1:0] BW_64 = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEAT = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic logic [3:0] nbytes(input logic [1:0] enc);
      logic [3:0] n;
      case (enc)
         SZ_1B:   n = 4'd1;
         SZ_2B:   n = 4'd2;
         SZ_4B:   n = 4'd4;
         SZ_8B:   n = 4'd8;
         default: n = 4'd1;
      endcase
      return n;
   endfunction

   function automatic logic [3:0] bus_nbytes(input logic [1:0] enc);
      logic [3:0] n;
      case (enc)
         BW_8:    n = 4'd1;
         BW_16:   n = 4'd2;
         BW_32:   n = 4'd4;
         BW_64:   n = 4'd8;
         default: n = 4'd1;
      endcase
      return n;
   endfunction

   // Byte lanes [off, off+nb) set; lanes past 7 simply drop off the top.
   function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [3:0] nb);
      logic [7:0] m;
      m = '0;
      for (int k = 0; k < 8; k++) begin
         m[k] = (4'(k) >= {1'b0, off}) && (4'(k) < ({1'b0, off} + nb));
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_lane_select.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_lane_select
//  Purpose  : Shifts the addressed item down by offset bytes and zero-fills
//             every byte above the item size.
//  Revision : 1.0 - initial release
// ============================================================================
module dbus_lane_select
   import dbus_pkg::*;
(
   input  logic [63:0] din,
   input  logic [2:0]  offset,
   input  logic [1:0]  size,
   output logic [63:0] dout
);

   logic [3:0] w_nb;

   assign w_nb = nbytes(size);

   for (genvar j = 0; j < 8; j++) begin : g_byte
      logic [3:0] w_src;
      logic       w_keep;

      assign w_src  = {1'b0, offset} + 4'(j);
      assign w_keep = (4'(j) < w_nb) && !w_src[3];
      assign dout[8*j +: 8] = w_keep ? din[{w_src[2:0], 3'b000} +: 8] : 8'h00;
   end

endmodule
`default_nettype wire

// File: rtl/dbus_down_pack.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_down_pack
//  Purpose  : Collects 8/16/32/64-bit read beats into 64-bit lane positions and
//             returns the addressed item right-justified and zero-extended.
//  Revision : 1.0 - initial release
// ============================================================================
module dbus_down_pack
   import dbus_pkg::*;
(
   input  logic        sys_clk,
   input  logic        resetl,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_addr,
   input  logic [1:0]  req_size,
   input  logic [1:0]  req_busw,
   input  logic        mem_valid,
   input  logic [63:0] mem_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [63:0] rd_data,
   output logic        rd_err,
   output logic        stray
);

   state_t      r_state;
   state_t      w_next;

   logic [2:0]  r_addr;
   logic [1:0]  r_size;
   logic [1:0]  r_busw;
   logic [2:0]  r_beats_m1;
   logic [2:0]  r_cnt;
   logic [63:0] r_asm;
   logic [63:0] r_rd_data;
   logic        r_rd_valid;
   logic        r_rd_err;
   logic        r_stray;

   logic        w_req_ready;
   logic        w_accept;
   logic        w_beat_take;
   logic        w_out_take;

   // Request-side decode
   logic [3:0]  w_req_nb;
   logic [2:0]  w_align_mask;
   logic        w_misaligned;
   logic [3:0]  w_req_beats;
   logic [2:0]  w_req_beats_m1;

   assign w_req_nb     = nbytes(req_size);
   assign w_align_mask = 3'(w_req_nb - 4'd1);
   assign w_misaligned = |(req_addr & w_align_mask);
   assign w_req_beats  = 4'd1 << (req_size - req_busw);
   assign w_req_beats_m1 = (req_size > req_busw) ? 3'(w_req_beats - 4'd1) : 3'd0;

   // Beat placement: narrow items start at the bus-aligned base, beat i goes i*bus_bytes higher
   logic [3:0]  w_bus_nb;
   logic [2:0]  w_bus_mask;
   logic [2:0]  w_base;
   logic [2:0]  w_step;
   logic [2:0]  w_off;
   logic [7:0]  w_lane_en;
   logic [63:0] w_bit_mask;
   logic [63:0] w_shift;
   logic [63:0] w_merged;
   logic [63:0] w_sel;
   logic        w_last;

   assign w_bus_nb   = bus_nbytes(r_busw);
   assign w_bus_mask = 3'(w_bus_nb - 4'd1);
   assign w_base     = r_addr & ~w_bus_mask;
   assign w_step     = r_cnt << r_busw;
   assign w_off      = w_base + w_step;
   assign w_lane_en  = lane_mask(w_off, w_bus_nb);
   assign w_shift    = mem_data << {w_off, 3'b000};
   assign w_merged   = (r_asm & ~w_bit_mask) | (w_shift & w_bit_mask);
   assign w_last     = (r_cnt == r_beats_m1);

   for (genvar k = 0; k < 8; k++) begin : g_lane
      assign w_bit_mask[8*k +: 8] = {8{w_lane_en[k]}};
   end

   dbus_lane_select u_sel (
      .din    (w_merged),
      .offset (r_addr),
      .size   (r_size),
      .dout   (w_sel)
   );

   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_req_ready = 1'b0;
      w_accept    = 1'b0;
      w_beat_take = 1'b0;
      w_out_take  = 1'b0;
      case (r_state)
         IDLE: begin
            w_req_ready = 1'b1;
            if (req_valid) begin
               w_accept = 1'b1;
               w_next   = w_misaligned ? HOLD : BEAT;
            end
         end
         BEAT: begin
            if (mem_valid) begin
               w_beat_take = 1'b1;
               if (w_last) begin
                  w_next = HOLD;
               end
            end
         end
         HOLD: begin
            if (rd_ready) begin
               w_out_take = 1'b1;
               w_next     = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         r_addr     <= '0;
         r_size     <= '0;
         r_busw     <= '0;
         r_beats_m1 <= '0;
         r_cnt      <= '0;
         r_asm      <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_err   <= 1'b0;
         r_stray    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_busw     <= req_busw;
            r_beats_m1 <= w_req_beats_m1;
            r_cnt      <= '0;
            r_asm      <= '0;
            if (w_misaligned) begin
               r_rd_data  <= '0;
               r_rd_valid <= 1'b1;
               r_rd_err   <= 1'b1;
            end
         end
         if (w_beat_take) begin
            r_asm <= w_merged;
            r_cnt <= r_cnt + 3'd1;
            if (w_last) begin
               r_rd_data  <= w_sel;
               r_rd_valid <= 1'b1;
               r_rd_err   <= 1'b0;
            end
         end
         if (w_out_take) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
         end
         if (mem_valid && (r_state != BEAT)) begin
            r_stray <= 1'b1;
         end
      end
   end

   assign req_ready = w_req_ready;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;
   assign rd_err    = r_rd_err;
   assign stray     = r_stray;

endmodule
`default_nettype wire

// File: tb/tb_dbus_down_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbus_down_pack
//  Purpose  : Table-driven self-checking bench with a result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_down_pack;

   logic        sys_clk   = 1'b0;
   logic        resetl    = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_addr  = '0;
   logic [1:0]  req_size  = '0;
   logic [1:0]  req_busw  = '0;
   logic        mem_valid = 1'b0;
   logic [63:0] mem_data  = '0;
   logic        rd_valid;
   logic        rd_ready  = 1'b0;
   logic [63:0] rd_data;
   logic        rd_err;
   logic        stray;

   always #5 sys_clk = ~sys_clk;

   dbus_down_pack u_dut (
      .sys_clk   (sys_clk),
      .resetl    (resetl),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .req_busw  (req_busw),
      .mem_valid (mem_valid),
      .mem_data  (mem_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_err    (rd_err),
      .stray     (stray)
   );

   typedef struct packed {
      logic [2:0]        addr;
      logic [1:0]        size;
      logic [1:0]        busw;
      logic [3:0]        nbeats;
      logic [3:0][63:0]  beat;
      logic [3:0]        gap;
      logic [63:0]       exp_data;
      logic              exp_err;
   } vec_t;

   typedef struct packed {
      logic [63:0] data;
      logic        err;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] a, input logic [1:0] s, input logic [1:0] bw,
                               input int nb, input logic [63:0] b0, input logic [63:0] b1,
                               input logic [63:0] b2, input logic [63:0] b3, input int gap,
                               input logic [63:0] ed, input logic ee);
      vec_t v;
      v.addr = a; v.size = s; v.busw = bw; v.nbeats = 4'(nb);
      v.beat[0] = b0; v.beat[1] = b1; v.beat[2] = b2; v.beat[3] = b3;
      v.gap = 4'(gap); v.exp_data = ed; v.exp_err = ee;
      return v;
   endfunction

   // Drives one request and its beats, then retires the result from the scoreboard.
   task automatic run_vec(input vec_t v, input string tag);
      exp_t e;
      int   t;
      chk({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
      req_addr = v.addr; req_size = v.size; req_busw = v.busw; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      e.data = v.exp_data; e.err = v.exp_err;
      sb.push_back(e);
      for (int i = 0; i < int'(v.nbeats); i++) begin
         for (int g = 0; g < int'(v.gap); g++) tick();
         chk($sformatf("%s req_ready busy b%0d", tag, i), 64'(req_ready), 64'd0);
         chk($sformatf("%s rd_valid early b%0d", tag, i), 64'(rd_valid), 64'd0);
         mem_data = v.beat[i]; mem_valid = 1'b1;
         tick();
         mem_valid = 1'b0; mem_data = '0;
      end
      chk({tag, " latency"}, 64'(rd_valid), 64'd1);
      t = 0;
      while (!rd_valid && t < 20) begin
         tick();
         t++;
      end
      if (!rd_valid) begin
         checks++; errors++;
         $display("FAIL %s timeout rd_valid actual=0 required=1", tag);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         chk({tag, " rd_data"}, rd_data, e.data);
         chk({tag, " rd_err"}, 64'(rd_err), 64'(e.err));
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      chk({tag, " rd_valid drop"}, 64'(rd_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

   initial begin
      exp_t e;

      vecs.push_back(mk(3'd5, 2'd0, 2'd3, 1, 64'h1122334455667788, 0, 0, 0, 0, 64'h33, 1'b0));
      vecs.push_back(mk(3'd0, 2'd3, 2'd1, 4, 64'h2211, 64'h4433, 64'h6655, 64'h8877, 2,
                        64'h8877665544332211, 1'b0));
      vecs.push_back(mk(3'd6, 2'd1, 2'd2, 1, 64'hAABBCCDD, 0, 0, 0, 0, 64'hAABB, 1'b0));
      vecs.push_back(mk(3'd3, 2'd2, 2'd2, 0, 0, 0, 0, 0, 0, 64'h0, 1'b1));
      vecs.push_back(mk(3'd4, 2'd2, 2'd0, 4, 64'hFFFFFFFFFFFFFFA1, 64'hFFFFFFFFFFFFFFB2,
                        64'hFFFFFFFFFFFFFFC3, 64'hFFFFFFFFFFFFFFD4, 1, 64'hD4C3B2A1, 1'b0));
      vecs.push_back(mk(3'd0, 2'd3, 2'd3, 1, 64'h0123456789ABCDEF, 0, 0, 0, 0,
                        64'h0123456789ABCDEF, 1'b0));
      vecs.push_back(mk(3'd2, 2'd1, 2'd3, 1, 64'h0123456789ABCDEF, 0, 0, 0, 0, 64'h89AB, 1'b0));
      vecs.push_back(mk(3'd0, 2'd3, 2'd2, 2, 64'hDEADBEEF33221100, 64'hCAFEF00D77665544, 0, 0, 1,
                        64'h7766554433221100, 1'b0));
      vecs.push_back(mk(3'd7, 2'd0, 2'd1, 1, 64'h5A3C, 0, 0, 0, 0, 64'h5A, 1'b0));
      vecs.push_back(mk(3'd1, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 64'h0, 1'b1));
      vecs.push_back(mk(3'd7, 2'd0, 2'd3, 1, 64'h80FFFFFFFFFFFFFF, 0, 0, 0, 0, 64'h80, 1'b0));
      vecs.push_back(mk(3'd4, 2'd2, 2'd1, 2, 64'h9988, 64'hBBAA, 0, 0, 0, 64'hBBAA9988, 1'b0));
      vecs.push_back(mk(3'd0, 2'd0, 2'd2, 1, 64'h44332211, 0, 0, 0, 0, 64'h11, 1'b0));

      repeat (3) tick();
      chk("reset req_ready", 64'(req_ready), 64'd1);
      chk("reset rd_valid", 64'(rd_valid), 64'd0);
      chk("reset rd_data", rd_data, 64'd0);
      chk("reset rd_err", 64'(rd_err), 64'd0);
      chk("reset stray", 64'(stray), 64'd0);
      resetl = 1'b1;
      tick();

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end
      chk("stray quiet", 64'(stray), 64'd0);

      // Result held through a stalled consumer while a stray beat arrives
      req_addr = 3'd0; req_size = 2'd3; req_busw = 2'd3; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      e.data = 64'h0F0E0D0C0B0A0908; e.err = 1'b0;
      sb.push_back(e);
      mem_data = 64'h0F0E0D0C0B0A0908; mem_valid = 1'b1;
      tick();
      mem_valid = 1'b0; mem_data = '0;
      chk("hold latency", 64'(rd_valid), 64'd1);
      e = sb.pop_front();
      chk("hold rd_data", rd_data, e.data);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            mem_valid = 1'b1; mem_data = '1;
         end
         tick();
         mem_valid = 1'b0; mem_data = '0;
         chk($sformatf("hold valid c%0d", c), 64'(rd_valid), 64'd1);
         chk($sformatf("hold data c%0d", c), rd_data, e.data);
         chk($sformatf("hold req_ready c%0d", c), 64'(req_ready), 64'd0);
      end
      chk("stray set", 64'(stray), 64'd1);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      chk("hold release", 64'(rd_valid), 64'd0);

      // Reset mid-assembly, then a clean request
      req_addr = 3'd0; req_size = 2'd3; req_busw = 2'd1; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      mem_data = 64'h1111; mem_valid = 1'b1;
      tick();
      mem_data = 64'h2222;
      tick();
      mem_valid = 1'b0; mem_data = '0;
      resetl = 1'b0;
      #1;
      chk("midrst req_ready", 64'(req_ready), 64'd1);
      chk("midrst rd_valid", 64'(rd_valid), 64'd0);
      chk("midrst rd_data", rd_data, 64'd0);
      chk("midrst rd_err", 64'(rd_err), 64'd0);
      chk("midrst stray", 64'(stray), 64'd0);
      #2;
      resetl = 1'b1;
      run_vec(mk(3'd0, 2'd3, 2'd1, 4, 64'h0201, 64'h0403, 64'h0605, 64'h0807, 0,
                 64'h0807060504030201, 1'b0), "post_rst");

      chk("scoreboard empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
